fetch_sequencer: RTL and testbench

- Controller for the program-counter register and the instruction-memory port of the single-cycle RV32I core.
- Each cycle it drives the PC's next_sel/next_address, so the PC holds, advances by 4, or is redirected.
- Issues one instruction-fetch request at a time using a req/gnt/rvalid handshake, and buffers the returned word until the decoder accepts it.
- Arbitrates redirect sources with priority trap > mret > branch, and traps on misaligned targets.

---
 rtl/fetch_sequencer.sv | 81 ++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC control and single-outstanding instruction fetch for an RV32I core.
// Ports: clk/rst (async active-low); pc_in -> next_sel/next_address drive the PC;
// imem_req/imem_gnt/imem_rvalid/imem_rdata fetch from pc_in; instr_out/instr_valid/dec_ready
// hand the word to the decoder; branch_taken/branch_target, trap_req, mret_req/mepc_in redirect;
// epc_out holds the PC of the last trap; misaligned_err pulses on a misaligned redirect.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        next_sel,
  output logic [31:0] next_address,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic [31:0] mepc_in,
  output logic [31:0] epc_out,
  output logic        misaligned_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_d;
  logic kill, kill_d, redir, mis, capture;
  logic [31:0] raw_target, target;
  always_comb begin
    redir = state != IDLE && (trap_req || mret_req || branch_taken);
    raw_target = trap_req ? TRAP_VECTOR : mret_req ? mepc_in : branch_target;
    mis = redir && !trap_req && raw_target[1:0] != 2'b00;
    target = (trap_req || mis) ? TRAP_VECTOR : raw_target;
    next_sel = !(state == HOLD && dec_ready && !redir);
    next_address = state == IDLE ? RESET_VECTOR : redir ? target : pc_in;
    imem_req = state == REQ;
    instr_valid = state == HOLD;
    capture = state == WAIT && imem_rvalid && !kill && !redir;
    state_d = state;
    kill_d = kill;
    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        state_d = imem_gnt ? WAIT : REQ;
        // a grant that coincides with a redirect still returns data; drop it
        kill_d = imem_gnt && redir;
      end
      WAIT: begin
        state_d = imem_rvalid ? (capture ? HOLD : REQ) : WAIT;
        kill_d = !imem_rvalid && (kill || redir);
      end
      HOLD: state_d = (redir || dec_ready) ? REQ : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      kill <= 1'b0;
    end else begin
      state <= state_d;
      kill <= kill_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_out <= '0;
      epc_out <= '0;
      misaligned_err <= 1'b0;
    end else begin
      instr_out <= capture ? imem_rdata : instr_out;
      misaligned_err <= mis;
      epc_out <= (redir && (trap_req || mis)) ? pc_in : epc_out;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch handshake, PC control and redirects.
module tb_fetch_sequencer;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc, next_address, imem_rdata = '0, instr_out, branch_target = '0, mepc_in = '0, epc_out;
  logic next_sel, imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_valid, dec_ready = 1'b0;
  logic branch_taken = 1'b0, trap_req = 1'b0, mret_req = 1'b0, misaligned_err;
  int cmp = 0, errs = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc_in(pc), .next_sel(next_sel), .next_address(next_address),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .dec_ready(dec_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .trap_req(trap_req),
    .mret_req(mret_req), .mepc_in(mepc_in), .epc_out(epc_out), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  // the PC register this block steers; its reset value differs from RESET_VECTOR on purpose
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'h0000_0A00;
    else pc <= next_sel ? next_address : pc + 32'd4;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    cmp++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", imem_req); end
    cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    cmp++; if (instr_out !== 32'h0) begin errs++; $display("FAIL rst_instr got %h want 0", instr_out); end
    cmp++; if (epc_out !== 32'h0) begin errs++; $display("FAIL rst_epc got %h want 0", epc_out); end
    cmp++; if (misaligned_err !== 1'b0) begin errs++; $display("FAIL rst_mis got %b want 0", misaligned_err); end
    cmp++; if (next_sel !== 1'b1) begin errs++; $display("FAIL rst_sel got %b want 1", next_sel); end
    cmp++; if (next_address !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 0", next_address); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmp++; if (pc !== 32'(i * 4)) begin errs++; $display("FAIL fetch_pc got %h want %h", pc, 32'(i * 4)); end
      cmp++; if (imem_req !== 1'b1) begin errs++; $display("FAIL fetch_req got %b want 1", imem_req); end
      cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL fetch_vreq got %b want 0", instr_valid); end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      cmp++; if (imem_req !== 1'b0) begin errs++; $display("FAIL fetch_wait_req got %b want 0", imem_req); end
      imem_rvalid = 1'b1;
      imem_rdata = 32'h0000_0013;
      step();
      imem_rvalid = 1'b0;
      cmp++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL fetch_valid got %b want 1", instr_valid); end
      cmp++; if (instr_out !== 32'h13) begin errs++; $display("FAIL fetch_instr got %h want 13", instr_out); end
      cmp++; if (next_sel !== 1'b0) begin errs++; $display("FAIL fetch_adv got %b want 0", next_sel); end
      step();
    end
  endtask

  task automatic test_hold();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00A0_0093;
    dec_ready = 1'b0;
    step();
    imem_rvalid = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      cmp++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL hold_valid got %b want 1", instr_valid); end
      cmp++; if (next_sel !== 1'b1) begin errs++; $display("FAIL hold_sel got %b want 1", next_sel); end
      cmp++; if (next_address !== 32'hC) begin errs++; $display("FAIL hold_addr got %h want c", next_address); end
      cmp++; if (pc !== 32'hC) begin errs++; $display("FAIL hold_pc got %h want c", pc); end
      cmp++; if (instr_out !== 32'h00A0_0093) begin errs++; $display("FAIL hold_instr got %h want 00a00093", instr_out); end
      step();
    end
    dec_ready = 1'b1;
    #1;
    cmp++; if (next_sel !== 1'b0) begin errs++; $display("FAIL hold_rel_sel got %b want 0", next_sel); end
    step();
    cmp++; if (pc !== 32'h10) begin errs++; $display("FAIL hold_rel_pc got %h want 10", pc); end
    cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL hold_rel_valid got %b want 0", instr_valid); end
  endtask

  task automatic test_branch_kill();
    dec_ready = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    #1;
    cmp++; if (next_sel !== 1'b1 || next_address !== 32'h40) begin errs++; $display("FAIL kill_redir got %b/%h want 1/40", next_sel, next_address); end
    step();
    branch_taken = 1'b0;
    step();
    cmp++; if (imem_req !== 1'b0) begin errs++; $display("FAIL kill_wait_req got %b want 0", imem_req); end
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL kill_valid got %b want 0", instr_valid); end
    cmp++; if (imem_req !== 1'b1) begin errs++; $display("FAIL kill_req got %b want 1", imem_req); end
    cmp++; if (pc !== 32'h40) begin errs++; $display("FAIL kill_pc got %h want 40", pc); end
    cmp++; if (instr_out !== 32'h00A0_0093) begin errs++; $display("FAIL kill_instr got %h want 00a00093", instr_out); end
  endtask

  task automatic test_priority();
    branch_taken = 1'b1;
    branch_target = 32'h24;
    step();
    branch_taken = 1'b0;
    cmp++; if (pc !== 32'h24) begin errs++; $display("FAIL prio_pc0 got %h want 24", pc); end
    trap_req = 1'b1;
    mret_req = 1'b1;
    mepc_in = 32'h80;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    #1;
    cmp++; if (next_sel !== 1'b1 || next_address !== 32'h100) begin errs++; $display("FAIL prio_addr got %b/%h want 1/100", next_sel, next_address); end
    step();
    trap_req = 1'b0;
    mret_req = 1'b0;
    branch_taken = 1'b0;
    cmp++; if (epc_out !== 32'h24) begin errs++; $display("FAIL prio_epc got %h want 24", epc_out); end
    cmp++; if (pc !== 32'h100) begin errs++; $display("FAIL prio_pc got %h want 100", pc); end
    cmp++; if (misaligned_err !== 1'b0) begin errs++; $display("FAIL prio_mis got %b want 0", misaligned_err); end
  endtask

  task automatic test_misaligned();
    branch_taken = 1'b1;
    branch_target = 32'h42;
    #1;
    cmp++; if (next_address !== 32'h100) begin errs++; $display("FAIL mis_addr got %h want 100", next_address); end
    step();
    branch_taken = 1'b0;
    cmp++; if (misaligned_err !== 1'b1) begin errs++; $display("FAIL mis_err got %b want 1", misaligned_err); end
    cmp++; if (epc_out !== 32'h100) begin errs++; $display("FAIL mis_epc got %h want 100", epc_out); end
    cmp++; if (pc !== 32'h100) begin errs++; $display("FAIL mis_pc got %h want 100", pc); end
    step();
    cmp++; if (misaligned_err !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b want 0", misaligned_err); end
    branch_taken = 1'b1;
    branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    cmp++; if (misaligned_err !== 1'b0) begin errs++; $display("FAIL mis_aligned got %b want 0", misaligned_err); end
    cmp++; if (pc !== 32'h200) begin errs++; $display("FAIL mis_aligned_pc got %h want 200", pc); end
    cmp++; if (epc_out !== 32'h100) begin errs++; $display("FAIL mis_aligned_epc got %h want 100", epc_out); end
  endtask

  task automatic test_back_to_back();
    dec_ready = 1'b1;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    cmp++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid got %b want 1", instr_valid); end
    branch_taken = 1'b1;
    branch_target = 32'h300;
    #1;
    cmp++; if (next_sel !== 1'b1 || next_address !== 32'h300) begin errs++; $display("FAIL b2b_redir got %b/%h want 1/300", next_sel, next_address); end
    step();
    branch_taken = 1'b0;
    cmp++; if (pc !== 32'h300) begin errs++; $display("FAIL b2b_pc got %h want 300", pc); end
    cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL b2b_drop got %b want 0", instr_valid); end
    cmp++; if (imem_req !== 1'b1) begin errs++; $display("FAIL b2b_req got %b want 1", imem_req); end
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    cmp++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mid_req got %b want 0", imem_req); end
    cmp++; if (next_sel !== 1'b1 || next_address !== 32'h0) begin errs++; $display("FAIL mid_addr got %b/%h want 1/0", next_sel, next_address); end
    cmp++; if (epc_out !== 32'h0 || instr_out !== 32'h0) begin errs++; $display("FAIL mid_regs got %h/%h want 0/0", epc_out, instr_out); end
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBADC_0DE0;
    rst = 1'b1;
    step();
    imem_rvalid = 1'b0;
    cmp++; if (pc !== 32'h0) begin errs++; $display("FAIL mid_pc got %h want 0", pc); end
    cmp++; if (imem_req !== 1'b1) begin errs++; $display("FAIL mid_req2 got %b want 1", imem_req); end
    cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL mid_stray got %b want 0", instr_valid); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    cmp++; if (instr_valid !== 1'b1 || instr_out !== 32'h13) begin errs++; $display("FAIL mid_resume got %b/%h want 1/13", instr_valid, instr_out); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_hold();
    test_branch_kill();
    test_priority();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
